// File: rtl/oneshot_pkg.sv
// Shared constants for the one-shot pulse scheduler: FSM state encodings and
// the cycle-counter width helper.
package oneshot_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t PULSE = 2'd1;
  localparam state_t GAP   = 2'd2;

  // Counter must hold max(pulse_w, gap_w); never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned pulse_w,
                                            input int unsigned gap_w);
    int unsigned m;
    m = (pulse_w > gap_w) ? pulse_w : gap_w;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/oneshot_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of pending searching upward
// from ptr+1 (wrapping), returned as one-hot grant and binary index.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] c;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    c     = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      c = IW'((32'(ptr) + off) % N);
      if (!found && pending[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/oneshot_sched.sv
// Shared fixed-width one-shot pulse generator, round-robin among N_CH channels.
// Optional ONESHOT_SCHED_OVERRUN_EN adds sticky per-channel overrun flags.
module oneshot_sched
  import oneshot_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         req,
`ifdef ONESHOT_SCHED_OVERRUN_EN
  input  logic [N_CH-1:0]         ovr_clr,
  output logic [N_CH-1:0]         overrun,
`endif
  output logic                    pulse_out,
  output logic [N_CH-1:0]         pulse_ch,
  output logic [$clog2(N_CH)-1:0] pulse_idx,
  output logic [N_CH-1:0]         done,
  output logic [N_CH-1:0]         pending,
  output logic                    busy
);

  localparam int IW    = $clog2(N_CH);
  localparam int CNT_W = cnt_width(PULSE_W, GAP_W);
  localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IW-1:0]     ptr;
  logic [N_CH-1:0]   req_q;
  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   pick_grant;
  logic [IW-1:0]     pick_idx;

  rr_pick #(.N(N_CH)) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .grant   (pick_grant),
    .idx     (pick_idx)
  );

  always_comb begin
    rise  = req & ~req_q;
    grant = (state == IDLE) ? pick_grant : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= IW'(N_CH - 1);
      req_q     <= '0;
      pending   <= '0;
      pulse_out <= 1'b0;
      pulse_ch  <= '0;
      pulse_idx <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~grant) | rise;
      done    <= '0;
      case (state)
        IDLE: begin
          if (|pending) begin
            state     <= PULSE;
            cnt       <= '0;
            pulse_out <= 1'b1;
            pulse_ch  <= grant;
            pulse_idx <= pick_idx;
            ptr       <= pick_idx;
            busy      <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == PW_LAST) begin
            // pulse_ch still names the owner here, so it doubles as the done strobe
            done      <= pulse_ch;
            pulse_out <= 1'b0;
            pulse_ch  <= '0;
            pulse_idx <= '0;
            cnt       <= '0;
            if (GAP_W > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ONESHOT_SCHED_OVERRUN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun <= '0;
    else          overrun <= (overrun & ~ovr_clr) | (rise & pending & ~grant);
  end
`else
  // Repeat edges on an already-pending channel merge silently into pending.
`endif

endmodule

// File: tb/tb_oneshot_sched.sv
// Directed self-checking bench for oneshot_sched at default parameters.
// Define ONESHOT_SCHED_OVERRUN_EN to also exercise the overrun flags.
module tb_oneshot_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       pulse_out;
  logic [3:0] pulse_ch;
  logic [1:0] pulse_idx;
  logic [3:0] done;
  logic [3:0] pending;
  logic       busy;
`ifdef ONESHOT_SCHED_OVERRUN_EN
  logic [3:0] ovr_clr;
  logic [3:0] overrun;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oneshot_sched #(.N_CH(4), .PULSE_W(4), .GAP_W(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
`ifdef ONESHOT_SCHED_OVERRUN_EN
    .ovr_clr   (ovr_clr),
    .overrun   (overrun),
`endif
    .pulse_out (pulse_out),
    .pulse_ch  (pulse_ch),
    .pulse_idx (pulse_idx),
    .done      (done),
    .pending   (pending),
    .busy      (busy)
  );

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
`ifdef ONESHOT_SCHED_OVERRUN_EN
    ovr_clr = '0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = '0;
`ifdef ONESHOT_SCHED_OVERRUN_EN
    ovr_clr = '0;
`endif
    @(negedge clk);
    checks++; if (pulse_out !== 1'b0) begin failures++; $display("FAIL rst_pulse_out got=%b exp=0", pulse_out); end
    checks++; if (pulse_ch !== 4'b0) begin failures++; $display("FAIL rst_pulse_ch got=%b exp=0000", pulse_ch); end
    checks++; if (pulse_idx !== 2'd0) begin failures++; $display("FAIL rst_pulse_idx got=%0d exp=0", pulse_idx); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL rst_done got=%b exp=0000", done); end
    checks++; if (pending !== 4'b0) begin failures++; $display("FAIL rst_pending got=%b exp=0000", pending); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
`ifdef ONESHOT_SCHED_OVERRUN_EN
    checks++; if (overrun !== 4'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0000", overrun); end
`endif
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (pulse_out !== 1'b0 || busy !== 1'b0 || pending !== 4'b0) begin
      failures++; $display("FAIL rst_idle got po=%b busy=%b pend=%b exp 0/0/0000", pulse_out, busy, pending);
    end
  endtask

  task automatic test_single();
    logic exp_po;
    logic exp_busy;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      req = (t == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      exp_po   = (t >= 1 && t <= 4);
      exp_busy = (t >= 1 && t <= 5);
      if (t == 0) begin
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL single_pending t=%0d got=%b exp=0100", t, pending); end
      end
      checks++; if (pulse_out !== exp_po) begin failures++; $display("FAIL single_pulse_out t=%0d got=%b exp=%b", t, pulse_out, exp_po); end
      checks++; if (pulse_ch !== (exp_po ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_pulse_ch t=%0d got=%b exp=%b", t, pulse_ch, exp_po ? 4'b0100 : 4'b0000); end
      checks++; if (pulse_idx !== (exp_po ? 2'd2 : 2'd0)) begin failures++; $display("FAIL single_pulse_idx t=%0d got=%0d exp=%0d", t, pulse_idx, exp_po ? 2 : 0); end
      checks++; if (done !== ((t == 5) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL single_done t=%0d got=%b", t, done); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL single_busy t=%0d got=%b exp=%b", t, busy, exp_busy); end
    end
  endtask

  task automatic test_multi();
    logic [3:0] exp_ch   [0:18];
    logic [3:0] exp_pend [0:18];
    logic [3:0] exp_done [0:18];
    exp_ch   = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2,
                 4'h2, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
    exp_pend = '{4'hB, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h8, 4'h8, 4'h8,
                 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_done = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,
                 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
    do_reset();
    for (int t = 0; t < 19; t++) begin
      req = (t == 0) ? 4'b1011 : 4'b0000;
      @(negedge clk);
      checks++; if (pulse_ch !== exp_ch[t]) begin failures++; $display("FAIL multi_pulse_ch t=%0d got=%b exp=%b", t, pulse_ch, exp_ch[t]); end
      checks++; if (pulse_out !== (|exp_ch[t])) begin failures++; $display("FAIL multi_pulse_out t=%0d got=%b exp=%b", t, pulse_out, |exp_ch[t]); end
      checks++; if (pending !== exp_pend[t]) begin failures++; $display("FAIL multi_pending t=%0d got=%b exp=%b", t, pending, exp_pend[t]); end
      checks++; if (done !== exp_done[t]) begin failures++; $display("FAIL multi_done t=%0d got=%b exp=%b", t, done, exp_done[t]); end
    end
  endtask

  task automatic test_hold();
    int rises;
    int highs;
    int bad_idx;
    logic prev_po;
    rises = 0; highs = 0; bad_idx = 0; prev_po = 1'b0;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      req = (t < 20) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (pulse_out && !prev_po) rises++;
      if (pulse_out) begin
        highs++;
        if (pulse_idx !== 2'd1) bad_idx++;
      end
      prev_po = pulse_out;
    end
    checks++; if (rises !== 1) begin failures++; $display("FAIL hold_pulse_count got=%0d exp=1", rises); end
    checks++; if (highs !== 4) begin failures++; $display("FAIL hold_high_cycles got=%0d exp=4", highs); end
    checks++; if (bad_idx !== 0) begin failures++; $display("FAIL hold_owner got=%0d wrong-idx cycles exp=0", bad_idx); end
  endtask

  task automatic test_back_to_back();
    logic r1;
    do_reset();
    for (int t = 0; t < 21; t++) begin
      r1  = (t == 2) || (t == 7) || (t == 8) || (t == 10);
      req = {2'b00, r1, (t == 0)};
`ifdef ONESHOT_SCHED_OVERRUN_EN
      ovr_clr = (t == 11) ? 4'b0010 : 4'b0000;
`endif
      @(negedge clk);
      if (t == 0) begin
        checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL b2b_pending0 got=%b exp=0001", pending); end
      end
      if (t == 7) begin
        checks++; if (pulse_ch !== 4'b0010) begin failures++; $display("FAIL b2b_grant1 got=%b exp=0010", pulse_ch); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL b2b_requeue got=%b exp=0010", pending); end
      end
      if (t == 11) begin
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL b2b_done1 got=%b exp=0010", done); end
      end
      if (t == 12) begin
        checks++; if (pulse_out !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", pulse_out); end
      end
      if (t == 13) begin
        checks++; if (pulse_ch !== 4'b0010 || pulse_idx !== 2'd1) begin failures++; $display("FAIL b2b_grant2 got ch=%b idx=%0d exp ch=0010 idx=1", pulse_ch, pulse_idx); end
      end
      if (t == 17) begin
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL b2b_done2 got=%b exp=0010", done); end
      end
      if (t == 20) begin
        checks++; if (pulse_out !== 1'b0 || busy !== 1'b0 || pending !== 4'b0) begin
          failures++; $display("FAIL b2b_drained got po=%b busy=%b pend=%b exp 0/0/0000", pulse_out, busy, pending);
        end
      end
`ifdef ONESHOT_SCHED_OVERRUN_EN
      if (t == 8) begin
        checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL ovr_on_grant got=%b exp=0000", overrun); end
      end
      if (t == 10) begin
        checks++; if (overrun !== 4'b0010) begin failures++; $display("FAIL ovr_set got=%b exp=0010", overrun); end
      end
      if (t == 11) begin
        checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL ovr_clr got=%b exp=0000", overrun); end
      end
`endif
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int t = 0; t < 26; t++) begin
      req = {(t != 8), 2'b00, (t % 2 == 0)};
      @(negedge clk);
      if (t == 1 || t == 13 || t == 25) begin
        checks++; if (pulse_out !== 1'b1 || pulse_idx !== 2'd0) begin failures++; $display("FAIL fair_ch0 t=%0d got po=%b idx=%0d exp po=1 idx=0", t, pulse_out, pulse_idx); end
      end
      if (t == 7 || t == 19) begin
        checks++; if (pulse_out !== 1'b1 || pulse_idx !== 2'd3) begin failures++; $display("FAIL fair_ch3 t=%0d got po=%b idx=%0d exp po=1 idx=3", t, pulse_out, pulse_idx); end
      end
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    int highs;
    do_reset();
    req = 4'b0010;
    repeat (2) @(negedge clk);
    checks++; if (pulse_out !== 1'b1) begin failures++; $display("FAIL arst_pre_pulse got=%b exp=1", pulse_out); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pulse_out !== 1'b0) begin failures++; $display("FAIL arst_pulse_out got=%b exp=0", pulse_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (pending !== 4'b0) begin failures++; $display("FAIL arst_pending got=%b exp=0000", pending); end
    checks++; if (pulse_ch !== 4'b0) begin failures++; $display("FAIL arst_pulse_ch got=%b exp=0000", pulse_ch); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (pending !== 4'b0010 || pulse_out !== 1'b0) begin failures++; $display("FAIL arst_level_edge got pend=%b po=%b exp pend=0010 po=0", pending, pulse_out); end
    @(negedge clk);
    checks++; if (pulse_out !== 1'b1 || pulse_idx !== 2'd1) begin failures++; $display("FAIL arst_repulse got po=%b idx=%0d exp po=1 idx=1", pulse_out, pulse_idx); end
    do_reset();
    highs = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (pulse_out) highs++;
    end
    checks++; if (highs !== 0) begin failures++; $display("FAIL arst_no_residual got=%0d high cycles exp=0", highs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_hold();
    test_back_to_back();
    test_fairness();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
